// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel streamer.
//   NUM_PIXELS / IMG_W : default frame geometry (28x28 image).
//   ADDR_W / PIX_W     : pixel RAM address width and pixel width.
//   COORD_W            : width of the row/column coordinates.
//   state_t            : streamer FSM encoding.
package pixel_pkg;
  localparam int NUM_PIXELS = 784;
  localparam int IMG_W      = 28;
  localparam int ADDR_W     = 10;
  localparam int PIX_W      = 8;
  localparam int COORD_W    = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO that captures pixel RAM read data and presents the head
// entry to the output stream.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : empties the FIFO (takes priority over push/pop)
//   push      : write push_data (caller never pushes into a full FIFO)
//   pop       : drop the head entry (caller never pops an empty FIFO)
//   data      : head entry
//   count     : number of valid entries, 0..2
module pixel_skid_fifo
  import pixel_pkg::*;
#(
  parameter int W = PIX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // NOTE: the storage is reset as well because its head drives the pixel
  // output directly, which must read as zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign data = mem[rd_ptr];

endmodule

// File: rtl/pixel_streamer.sv
// Streams one frame of pixels out of a synchronous pixel RAM as a
// valid/ready beat stream, tagged with row/column and a last flag.
//   clk, reset  : clock, asynchronous active-high reset
//   frame_ready : host flag; its rising edge starts a frame, dropping it aborts
//   cnn_addr    : registered RAM read address
//   cnn_data    : RAM read data, valid the cycle after cnn_addr changes
//   pix_valid / pix_ready / pix_data : output beat handshake and payload
//   pix_row, pix_col, pix_last       : beat coordinates and end-of-frame flag
//   busy        : high while streaming
//   frame_done  : one-cycle pulse after the last beat is accepted
module pixel_streamer
  import pixel_pkg::*;
#(
  parameter int NUM_PIXELS = pixel_pkg::NUM_PIXELS,
  parameter int IMG_W      = pixel_pkg::IMG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_ready,
  output logic [ADDR_W-1:0]  cnn_addr,
  input  logic [PIX_W-1:0]   cnn_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic [COORD_W-1:0] pix_row,
  output logic [COORD_W-1:0] pix_col,
  output logic               pix_last,
  output logic               busy,
  output logic               frame_done
);

  // One extra bit so the issue index can reach NUM_PIXELS itself.
  localparam int IDX_W = ADDR_W + 1;

  state_t             state_q, state_d;
  logic               frame_ready_q;
  logic [IDX_W-1:0]   issue_idx;
  logic [IDX_W-1:0]   out_idx;
  logic [COORD_W-1:0] row_q, col_q;
  logic               inflight_q;
  logic               frame_done_q;

  logic               start, abort, issue, push, accept, is_last, last_accept;
  logic [1:0]         fifo_count;
  logic [PIX_W-1:0]   fifo_head;
  logic [2:0]         occupancy;

  assign accept      = pix_valid && pix_ready;
  assign is_last     = (out_idx == IDX_W'(NUM_PIXELS - 1));
  assign last_accept = accept && is_last;

  // Entries that will be held once this cycle's pop and the read already in
  // flight have settled; a new read may only be issued if it will fit.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, accept};

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    issue   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_ready && !frame_ready_q) begin
          start   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        busy  = 1'b1;
        issue = frame_ready && (issue_idx < IDX_W'(NUM_PIXELS)) && (occupancy < 3'd2);
        // Accepting the final beat wins over a simultaneous abort.
        if (last_accept) begin
          state_d = DONE;
        end else if (!frame_ready) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (!frame_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A read issued last cycle lands now; on abort it is discarded.
  assign push = inflight_q && (state_q == STREAM) && !abort;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      frame_ready_q <= 1'b0;
      cnn_addr      <= '0;
      issue_idx     <= '0;
      out_idx       <= '0;
      row_q         <= '0;
      col_q         <= '0;
      inflight_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_ready_q <= frame_ready;
      inflight_q    <= issue;
      frame_done_q  <= last_accept;

      if (issue) begin
        cnn_addr  <= issue_idx[ADDR_W-1:0];
        issue_idx <= issue_idx + IDX_W'(1);
      end else if (start) begin
        issue_idx <= '0;
      end

      if (start) begin
        out_idx <= '0;
        row_q   <= '0;
        col_q   <= '0;
      end else if (accept) begin
        out_idx <= out_idx + IDX_W'(1);
        if (col_q == COORD_W'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= row_q + COORD_W'(1);
        end else begin
          col_q <= col_q + COORD_W'(1);
        end
      end
    end
  end

  pixel_skid_fifo #(
    .W (PIX_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .flush     (abort),
    .push      (push),
    .push_data (cnn_data),
    .pop       (accept),
    .data      (fifo_head),
    .count     (fifo_count)
  );

  assign pix_valid  = (fifo_count != 2'd0);
  assign pix_data   = fifo_head;
  assign pix_row    = row_q;
  assign pix_col    = col_q;
  assign pix_last   = pix_valid && is_last;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer: RAM holds addr mod 256, expected
// beats come from a frame-index model (data = i mod 256, row = i / 28,
// col = i mod 28, last on i = 783).
module tb_pixel_streamer;
  import pixel_pkg::*;

  localparam int N = 784;
  localparam int W = 28;

  logic         clk = 1'b0;
  logic         reset;
  logic         frame_ready;
  logic [9:0]   cnn_addr;
  logic [7:0]   cnn_data;
  logic         pix_valid;
  logic         pix_ready;
  logic [7:0]   pix_data;
  logic [4:0]   pix_row;
  logic [4:0]   pix_col;
  logic         pix_last;
  logic         busy;
  logic         frame_done;

  logic [7:0]   ram [1024];
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  // RAM read of the registered address: data valid one cycle after issue.
  assign cnn_data = ram[cnn_addr];

  pixel_streamer #(
    .NUM_PIXELS (N),
    .IMG_W      (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_ready (frame_ready),
    .cnn_addr    (cnn_addr),
    .cnn_data    (cnn_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_row     (pix_row),
    .pix_col     (pix_col),
    .pix_last    (pix_last),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_beat(input int k);
    return 32'({8'(k % 256), 5'(k / W), 5'(k % W), (k == N - 1)});
  endfunction

  function automatic logic [31:0] obs_beat();
    return 32'({pix_data, pix_row, pix_col, pix_last});
  endfunction

  function automatic logic [31:0] all_outs();
    return {cnn_addr, pix_valid, pix_data, pix_row, pix_col, pix_last, busy, frame_done};
  endfunction

  // Starts a frame with a fresh rising edge and consumes it.
  // stop_kind: 0 run to completion, 1 drop frame_ready at beat stop_beat,
  // 2 assert reset at beat stop_beat (reset is left asserted on return).
  task automatic stream_frame(input int ready_pct, input int stop_beat, input int stop_kind);
    int  k = 0;
    int  last_acc = -1;
    bit  prev_stall = 1'b0;
    bit  done = 1'b0;
    int  cnt;

    @(negedge clk); frame_ready = 1'b0; pix_ready = 1'b0;
    @(negedge clk); frame_ready = 1'b1;
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_lat1", 32'(pix_valid), 32'd0);
    @(negedge clk);
    chk("start_lat2", 32'(pix_valid), 32'd0);
    @(negedge clk);
    chk("start_lat3_valid", 32'(pix_valid), 32'd1);

    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (prev_stall) chk("stall_hold_valid", 32'(pix_valid), 32'd1);
      if (pix_valid) chk($sformatf("beat%0d", k), obs_beat(), exp_beat(k));

      if (stop_kind == 1 && k == stop_beat) begin
        frame_ready = 1'b0;
        pix_ready   = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(pix_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        cnt = 0;
        repeat (10) begin
          if (frame_done) cnt++;
          @(negedge clk);
        end
        chk("abort_no_done", 32'(cnt), 32'd0);
        done = 1'b1;
      end else if (stop_kind == 2 && k == stop_beat) begin
        reset       = 1'b1;
        frame_ready = 1'b0;
        pix_ready   = 1'b0;
        #1;
        chk("midframe_reset_outs", all_outs(), 32'd0);
        done = 1'b1;
      end else begin
        pix_ready  = ($urandom_range(99) < ready_pct);
        prev_stall = pix_valid && !pix_ready;
        if (pix_valid && pix_ready) begin
          k++;
          if (k == N) begin
            last_acc = cyc;
            @(negedge clk);
            chk("done_pulse", 32'(frame_done), 32'd1);
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_valid", 32'(pix_valid), 32'd0);
            chk("addr_hold", 32'(cnn_addr), 32'(N - 1));
            @(negedge clk);
            chk("done_one_cycle", 32'(frame_done), 32'd0);
            if (ready_pct >= 100) chk("throughput", 32'(last_acc), 32'(N - 1));
            done = 1'b1;
          end
        end
      end
    end
    if (!done) chk("timeout_beats", 32'(k), 32'(N));
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i % 256);

    reset       = 1'b1;
    frame_ready = 1'b0;
    pix_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", all_outs(), 32'd0);

    // Full-rate frame.
    stream_frame(100, 0, 0);

    // frame_ready stays high after completion: no second frame.
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (pix_valid || busy) cnt++;
    end
    chk("no_restream_level_high", 32'(cnt), 32'd0);

    // Drop then raise: second frame under random backpressure.
    stream_frame(50, 0, 0);

    // Abort at beat 300, then a clean restart from beat 0.
    stream_frame(50, 300, 1);
    stream_frame(100, 0, 0);

    // Reset at beat 100, stay idle, then a fresh frame.
    stream_frame(100, 100, 2);
    repeat (2) @(negedge clk);
    chk("reset_hold_outs", all_outs(), 32'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (all_outs() != 32'd0) cnt++;
    end
    chk("idle_after_midframe_reset", 32'(cnt), 32'd0);
    stream_frame(70, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_streamer.md
PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 Parameter NUM_PIXELS, default 784, pixels per frame (28x28).
REQ-002 Parameter IMG_W, default 28, pixels per row.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_ready  input  1  host-controlled flag; frame loaded in pixel RAM.
REQ-006 cnn_addr  output  10  registered read address to pixel RAM, 0..783.
REQ-007 cnn_data  input  8  RAM read data, valid exactly 1 cycle after cnn_addr is driven.
REQ-008 pix_valid  output  1  output stream beat valid.
REQ-009 pix_ready  input  1  downstream accepts beat when pix_valid && pix_ready.
REQ-010 pix_data  output  8  pixel value.
REQ-011 pix_row  output  5  row of current beat, 0..27.
REQ-012 pix_col  output  5  column of current beat, 0..27.
REQ-013 pix_last  output  1  high on the beat with index NUM_PIXELS-1.
REQ-014 busy  output  1  high in STREAM state.
REQ-015 frame_done  output  1  one-cycle pulse after last beat accepted.

Function
REQ-016 States SHALL be IDLE, STREAM, DONE.
REQ-017 IDLE->STREAM on rising edge of frame_ready (registered previous value 0, current 1); level-high alone SHALL NOT start a frame.
REQ-018 On entry to STREAM: issue index, output index, row, col counters SHALL be 0.
REQ-019 Read issue rule: issue address when issue index < NUM_PIXELS and (buffer occupancy + in-flight reads - pop this cycle) < 2; issue index increments by 1 per issue.
REQ-020 Each issued read's cnn_data SHALL be captured into a 2-entry FIFO one cycle later; no read data SHALL be dropped or duplicated.
REQ-021 pix_valid SHALL equal FIFO non-empty; pix_data is FIFO head; pix_valid SHALL NOT depend combinationally on pix_ready.
REQ-022 With pix_ready held high, sustained throughput SHALL be 1 beat/cycle; first beat pix_valid SHALL assert 2 cycles after the start edge is sampled.
REQ-023 Under pix_ready low, pix_valid/pix_data/pix_row/pix_col/pix_last SHALL hold stable.
REQ-024 On each accepted beat: col increments; at col==IMG_W-1 col wraps to 0 and row increments.
REQ-025 After beat NUM_PIXELS-1 accepted: frame_done pulses next cycle, state -> DONE.
REQ-026 DONE->IDLE when frame_ready is low; no re-stream while frame_ready stays high.
REQ-027 frame_ready falling while in STREAM SHALL abort: next cycle state IDLE, FIFO flushed, in-flight read discarded, pix_valid low, no frame_done.
REQ-028 Abort and last-beat acceptance in the same cycle: acceptance wins, frame_done pulses.
REQ-029 cnn_addr SHALL hold its last value when no read is issued.

Reset
REQ-030 While reset high: state IDLE, cnn_addr 0, pix_valid 0, pix_data 0, pix_row 0, pix_col 0, pix_last 0, busy 0, frame_done 0, FIFO empty, frame_ready history 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; after release a new frame_ready rising edge is required to start.

Structure
REQ-032 Shared package pixel_pkg SHALL hold NUM_PIXELS, IMG_W, address width 10, pixel width 8, and the state encoding.
REQ-033 The 2-entry FIFO SHALL be a sub-module pixel_skid_fifo (push, pop, data, count, flush).

Verification
REQ-034 RAM model preloaded addr[i]=i mod 256, pix_ready=1, frame_ready 0->1 -> 784 beats in 784 consecutive cycles, data i mod 256, pix_last only on beat 783 (row 27, col 27), frame_done one cycle later.
REQ-035 Random pix_ready (50%) -> same 784-value sequence, no gaps/duplicates, outputs stable while stalled.
REQ-036 frame_ready low at beat 300 -> pix_valid low next cycle, no frame_done; new rising edge restarts at beat 0 data 0.
REQ-037 frame_ready held high after frame_done -> no further beats; drop then raise -> second full frame.
REQ-038 reset pulse at beat 100 -> all outputs at reset values, idle until next frame_ready rising edge.
REQ-039 Beat 27 accepted -> next beat row 1 col 0; beat 28 data = RAM[28].
